dem_gio: RTL and testbench

Time-of-day counter that consumes the 1 Hz square wave from the divider stage. It counts HH:MM:SS in BCD in 24-hour format, and provides a button-driven set mode for hours and minutes. Outputs feed the 7-segment display multiplexer. All logic runs on the 50 MHz system clock. The slow wave is sampled as data, never used as a clock.

---
 rtl/dem_gio_pkg.sv | 12 +
 rtl/dem_bcd_2so.sv | 23 ++
 rtl/dem_gio.sv | 63 ++++++
 tb/tb_dem_gio.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/dem_gio_pkg.sv
// dem_gio_pkg: mode encoding and BCD field limits for the time-of-day counter
package dem_gio_pkg;
  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_SET_H = 2'd1,
    MODE_SET_M = 2'd2,
    MODE_BAD   = 2'd3
  } mode_e;
  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;
endpackage

// File: rtl/dem_bcd_2so.sv
// dem_bcd_2so: two-digit BCD modulo counter wrapping after MAX_T:MAX_U
module dem_bcd_2so #(
  parameter logic [3:0] MAX_T = 4'd5,
  parameter logic [3:0] MAX_U = 4'd9
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       wrap
);
  assign wrap = (tens == MAX_T) && (units == MAX_U);
  always_ff @(posedge clk_in) begin
    if (rst) begin
      tens  <= '0;
      units <= '0;
    end else if (inc) begin
      tens  <= wrap ? 4'd0 : (units == 4'd9) ? tens + 4'd1 : tens;
      units <= (wrap || units == 4'd9) ? 4'd0 : units + 4'd1;
    end
  end
endmodule

// File: rtl/dem_gio.sv
// dem_gio: 24-hour BCD time-of-day counter with button-driven hour/minute set mode
module dem_gio
  import dem_gio_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       sec_in,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] hh_t,
  output logic [3:0] hh_u,
  output logic [3:0] mm_t,
  output logic [3:0] mm_u,
  output logic [3:0] ss_t,
  output logic [3:0] ss_u,
  output logic [1:0] mode,
  output logic       tick_1s
);
  logic [SYNC_STAGES-1:0] sync;
  logic prev, tick_q, bm_p, bi_p;
  logic m_edge, i_edge, run, clr_s, inc_s, inc_m, inc_h, w_s, w_m;
  mode_e st;
  assign m_edge = btn_mode & ~bm_p;
  assign i_edge = btn_inc & ~bi_p & ~m_edge;
  assign run    = st == MODE_RUN;
  assign mode   = st;
  // Tick is registered once before the output flop, giving SYNC_STAGES+2 latency
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync    <= '1;
      prev    <= 1'b1;
      tick_q  <= 1'b0;
      tick_1s <= 1'b0;
      bm_p    <= 1'b1;
      bi_p    <= 1'b1;
      st      <= MODE_RUN;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], sec_in};
      prev    <= sync[SYNC_STAGES-1];
      tick_q  <= sync[SYNC_STAGES-1] & ~prev;
      tick_1s <= tick_q;
      bm_p    <= btn_mode;
      bi_p    <= btn_inc;
      st      <= (st == MODE_BAD || (m_edge && st == MODE_SET_M)) ? MODE_RUN :
                 m_edge ? mode_e'(st + 2'd1) : st;
    end
  end
  assign clr_s = rst | (m_edge & st == MODE_SET_M);
  assign inc_s = run & tick_1s;
  assign inc_m = (inc_s & w_s) | (st == MODE_SET_M & i_edge);
  assign inc_h = (inc_s & w_s & w_m) | (st == MODE_SET_H & i_edge);
  dem_bcd_2so #(.MAX_T(SEC_MAX[7:4]), .MAX_U(SEC_MAX[3:0])) u_sec (
    .clk_in(clk_in), .rst(clr_s), .inc(inc_s), .tens(ss_t), .units(ss_u), .wrap(w_s)
  );
  dem_bcd_2so #(.MAX_T(MIN_MAX[7:4]), .MAX_U(MIN_MAX[3:0])) u_min (
    .clk_in(clk_in), .rst(rst), .inc(inc_m), .tens(mm_t), .units(mm_u), .wrap(w_m)
  );
  dem_bcd_2so #(.MAX_T(HOUR_MAX[7:4]), .MAX_U(HOUR_MAX[3:0])) u_hour (
    .clk_in(clk_in), .rst(rst), .inc(inc_h), .tens(hh_t), .units(hh_u), .wrap()
  );
endmodule

// File: tb/tb_dem_gio.sv
// tb_dem_gio: directed plus randomized checks of dem_gio against an arithmetic time model
module tb_dem_gio;
  logic clk_in = 1'b0, rst = 1'b1, sec_in = 1'b1, btn_mode = 1'b0, btn_inc = 1'b0;
  logic [3:0] hh_t, hh_u, mm_t, mm_u, ss_t, ss_u;
  logic [1:0] mode;
  logic tick_1s;
  int errors = 0, checks = 0;
  int h = 0, m = 0, s = 0, md = 0;
  always #5 clk_in = ~clk_in;
  dem_gio #(.SYNC_STAGES(2)) dut (
    .clk_in(clk_in), .rst(rst), .sec_in(sec_in), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .hh_t(hh_t), .hh_u(hh_u), .mm_t(mm_t), .mm_u(mm_u), .ss_t(ss_t), .ss_u(ss_u),
    .mode(mode), .tick_1s(tick_1s)
  );
  function automatic logic [23:0] bcd(int a, int b, int c);
    return {4'(a / 10), 4'(a % 10), 4'(b / 10), 4'(b % 10), 4'(c / 10), 4'(c % 10)};
  endfunction
  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_state(string tag);
    chk({tag, " time"}, int'({hh_t, hh_u, mm_t, mm_u, ss_t, ss_u}), int'(bcd(h, m, s)));
    chk({tag, " mode"}, int'(mode), md);
  endtask
  task automatic step;
    @(posedge clk_in);
    #1;
  endtask
  task automatic advance;
    s++;
    if (s == 60) begin
      s = 0;
      m++;
      if (m == 60) begin
        m = 0;
        h = (h + 1) % 24;
      end
    end
  endtask
  task automatic do_tick(int hi, int lo);
    int first = 0, n = 0;
    if (md == 0) advance();
    step();
    sec_in = 1'b1;
    for (int k = 1; k <= hi + lo; k++) begin
      step();
      if (k == hi) sec_in = 1'b0;
      if (tick_1s) begin
        n++;
        if (first == 0) first = k;
      end
      if (k == 5) chk_state("tick update");
    end
    chk("tick latency", first, 4);
    chk("tick width", n, 1);
  endtask
  task automatic press_mode;
    btn_mode = 1'b1;
    repeat (3) step();
    btn_mode = 1'b0;
    repeat (3) step();
    if (md == 2) s = 0;
    md = (md + 1) % 3;
  endtask
  task automatic press_inc;
    btn_inc = 1'b1;
    repeat (3) step();
    btn_inc = 1'b0;
    repeat (3) step();
    if (md == 1) h = (h + 1) % 24;
    if (md == 2) m = (m + 1) % 60;
  endtask
  initial begin
    int n;
    repeat (3) step();
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (tick_1s) n++;
    end
    chk("no tick after reset with sec_in high", n, 0);
    chk_state("reset");
    sec_in = 1'b0;
    repeat (5) step();
    repeat (3) do_tick(10, 10);
    chk_state("three ticks");
    press_mode();
    repeat (25) press_inc();
    chk_state("set hours 25 incs");
    press_mode();
    repeat (61) press_inc();
    chk_state("set minutes 61 incs");
    repeat (2) do_tick(5, 5);
    chk_state("ticks frozen in set");
    press_mode();
    chk_state("exit to run");
    press_mode();
    repeat (22) press_inc();
    press_mode();
    repeat (58) press_inc();
    press_mode();
    chk_state("preload 23:59");
    repeat (59) do_tick(4, 4);
    chk_state("23:59:59");
    do_tick(4, 4);
    chk_state("full rollover");
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 2))
        0: do_tick($urandom_range(3, 8), $urandom_range(3, 8));
        1: press_inc();
        default: press_mode();
      endcase
      chk_state("random op");
    end
    while (md != 0) press_mode();
    step();
    sec_in = 1'b1;
    repeat (4) step();
    chk("coincident tick present", int'(tick_1s), 1);
    btn_mode = 1'b1;
    btn_inc = 1'b1;
    step();
    advance();
    md = 1;
    chk_state("coincident mode inc tick");
    sec_in = 1'b0;
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    repeat (6) step();
    chk_state("coincident settled");
    repeat ((12 - h + 24) % 24) press_inc();
    press_mode();
    repeat ((34 - m + 60) % 60) press_inc();
    press_mode();
    repeat (56) do_tick(4, 4);
    press_mode();
    press_mode();
    chk_state("12:34:56 in set minutes");
    rst = 1'b1;
    step();
    rst = 1'b0;
    h = 0;
    m = 0;
    s = 0;
    md = 0;
    chk_state("mid-set reset");
    chk("reset tick_1s", int'(tick_1s), 0);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (tick_1s) n++;
    end
    chk("no false tick with sec_in low", n, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
